key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 160 ++++++++++++++++
 tb/tb_key_conditioner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-key 2-flop synchronizer, debounce FSM, press pulse and sticky event flag.
// Define KEY_CONDITIONER_REPEAT_EN to emit auto-repeat presses while a key stays held.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] ack,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_event
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_SAT) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic [NUM_KEYS-1:0] meta_r;
  logic [NUM_KEYS-1:0] sync_r;

  // Two-flop synchronizer; released (high) is the reset level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {NUM_KEYS{1'b1}};
      sync_r <= {NUM_KEYS{1'b1}};
    end else begin
      meta_r <= key_n;
      sync_r <= meta_r;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             press_r;
    logic             event_r;
    logic             pressed_s;
`ifdef KEY_CONDITIONER_REPEAT_EN
    logic             rep_r;
`endif

    assign pressed_s = ~sync_r[i];

    // Per-key debounce FSM; level lags the HELD entry by one cycle, press wins over ack.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_r <= IDLE;
        cnt_r   <= CNT_ZERO;
        level_r <= 1'b0;
        press_r <= 1'b0;
        event_r <= 1'b0;
`ifdef KEY_CONDITIONER_REPEAT_EN
        rep_r   <= 1'b0;
`endif
      end else begin
        press_r <= 1'b0;
        event_r <= event_r & ~ack[i];
        level_r <= (state_r == HELD) || (state_r == RELEASE_WAIT);
        case (state_r)
          IDLE: begin
            cnt_r <= CNT_ZERO;
            if (pressed_s) begin
              state_r <= PRESS_WAIT;
            end else begin
              state_r <= IDLE;
            end
          end
          PRESS_WAIT: begin
            if (!pressed_s) begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO;
            end else if (cnt_r == DEB_LAST) begin
              state_r <= HELD;
              cnt_r   <= CNT_ZERO;
              press_r <= 1'b1;
              event_r <= 1'b1;
`ifdef KEY_CONDITIONER_REPEAT_EN
              rep_r   <= 1'b0;
`endif
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          HELD: begin
            if (!pressed_s) begin
              state_r <= RELEASE_WAIT;
              cnt_r   <= CNT_ZERO;
            end else begin
`ifdef KEY_CONDITIONER_REPEAT_EN
              // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
              if (cnt_r == (rep_r ? PER_LAST : DLY_LAST)) begin
                cnt_r   <= CNT_ZERO;
                rep_r   <= 1'b1;
                press_r <= 1'b1;
                event_r <= 1'b1;
              end else begin
                cnt_r <= sat_inc(cnt_r);
              end
`else
              cnt_r <= CNT_ZERO;
`endif
            end
          end
          RELEASE_WAIT: begin
            if (pressed_s) begin
              state_r <= HELD;
              cnt_r   <= CNT_ZERO;
`ifdef KEY_CONDITIONER_REPEAT_EN
              rep_r   <= 1'b0;
`endif
            end else if (cnt_r == DEB_LAST) begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO;
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end
        endcase
      end
    end

    assign key_level[i] = level_r;
    assign key_press[i] = press_r;
    assign key_event[i] = event_r;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key/ack/reset
// traffic, all checked every cycle against a run-length based debounce reference model.
module tb_key_conditioner;
  localparam int NK = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] ack;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_event;

  int vectors;
  int miscompares;

  // Reference model: synchronizer pipe, accepted level, mismatch run length, hold time.
  bit [NK-1:0] s1_m, s2_m, acc_m, lvl_m, prs_m, evt_m;
  int          run_m [NK];
  int          t_m   [NK];

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_n    (key_n),
    .ack      (ack),
    .key_level(key_level),
    .key_press(key_press),
    .key_event(key_event)
  );

  task automatic check_vec(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    s1_m  = '1;
    s2_m  = '1;
    acc_m = '0;
    lvl_m = '0;
    prs_m = '0;
    evt_m = '0;
    for (int i = 0; i < NK; i++) begin
      run_m[i] = 0;
      t_m[i]   = 0;
    end
  endtask

  // A key flips its accepted level after D+1 consecutive samples disagreeing with it.
  task automatic model_edge();
    bit [NK-1:0] lvl_n, prs_n, evt_n;
    for (int i = 0; i < NK; i++) begin
      bit pr;
      bit pulse;
      pr       = ~s2_m[i];
      pulse    = 1'b0;
      lvl_n[i] = acc_m[i];
      if (!acc_m[i]) begin
        run_m[i] = pr ? run_m[i] + 1 : 0;
        if (run_m[i] == D + 1) begin
          acc_m[i] = 1'b1;
          run_m[i] = 0;
          t_m[i]   = 0;
          pulse    = 1'b1;
        end
      end else if (!pr) begin
        run_m[i]++;
        if (run_m[i] == D + 1) begin
          acc_m[i] = 1'b0;
          run_m[i] = 0;
        end
      end else if (run_m[i] != 0) begin
        run_m[i] = 0;
        t_m[i]   = 0;
      end else begin
        t_m[i]++;
`ifdef KEY_CONDITIONER_REPEAT_EN
        if (t_m[i] == RD || (t_m[i] > RD && (t_m[i] - RD) % RP == 0)) pulse = 1'b1;
`endif
      end
      prs_n[i] = pulse;
      evt_n[i] = pulse | (evt_m[i] & ~ack[i]);
    end
    s2_m  = s1_m;
    s1_m  = key_n;
    lvl_m = lvl_n;
    prs_m = prs_n;
    evt_m = evt_n;
  endtask

  task automatic tick();
    if (reset_n) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    check_vec("level", key_level, lvl_m);
    check_vec("press", key_press, prs_m);
    check_vec("event", key_event, evt_m);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_vec({tag, "_level"}, key_level, 4'b0000);
    check_vec({tag, "_press"}, key_press, 4'b0000);
    check_vec({tag, "_event"}, key_event, 4'b0000);
  endtask

  initial begin
    int first, second, third, cnt, fall;
    bit [2:0] seen;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    key_n       = 4'b1111;
    ack         = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_level", key_level, 4'b0000);
    check_vec("reset_press", key_press, 4'b0000);
    check_vec("reset_event", key_event, 4'b0000);
    reset_n = 1'b1;
    idle(3);

    // Single press/hold/release on key 1.
    key_n[1] = 1'b0;
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (key_press[1]) begin
        if (first < 0) first = k;
        cnt++;
      end
    end
    check_int("r025_latency", first, D + 3);
`ifdef KEY_CONDITIONER_REPEAT_EN
    check_int("r025_count", cnt, 3);
`else
    check_int("r025_count", cnt, 1);
`endif
    key_n[1] = 1'b1;
    fall = -1;
    for (int k = 1; k <= D + 8; k++) begin
      tick();
      if (fall < 0 && !key_level[1]) fall = k;
    end
    check_int("r025_release", fall, D + 4);
    ack = 4'b1111;
    tick();
    ack = 4'b0000;

    // Bounces shorter than the debounce window on key 0.
    seen = 3'b000;
    for (int r = 0; r < 3; r++) begin
      key_n[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        seen |= {key_level[0], key_press[0], key_event[0]};
      end
      key_n[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        tick();
        seen |= {key_level[0], key_press[0], key_event[0]};
      end
    end
    for (int k = 0; k < D + 4; k++) begin
      tick();
      seen |= {key_level[0], key_press[0], key_event[0]};
    end
    check_int("r026_key0_quiet", int'(seen), 0);

    // Sticky event and ack handling on key 2.
    key_n[2] = 1'b0;
    idle(D + 3);
    check_int("r027_set", int'(key_event[2]), 1);
    idle(4);
    check_int("r027_persist", int'(key_event[2]), 1);
    ack[2] = 1'b1;
    tick();
    ack[2] = 1'b0;
    check_int("r027_clear", int'(key_event[2]), 0);
    key_n[2] = 1'b1;
    idle(D + 6);
    key_n[2] = 1'b0;
    for (int k = 1; k <= D + 3; k++) begin
      ack[2] = (k == D + 3);
      tick();
    end
    ack[2] = 1'b0;
    check_int("r027_set_wins", int'(key_event[2]), 1);
    tick();
    check_int("r027_set_hold", int'(key_event[2]), 1);
    ack[2] = 1'b1;
    tick();
    ack[2] = 1'b0;
    key_n[2] = 1'b1;
    idle(D + 6);

    // Simultaneous presses on keys 0 and 3.
    key_n = 4'b0110;
    idle(D + 3);
    check_vec("r030_simul", key_press, 4'b1001);
    key_n = 4'b1111;
    ack   = 4'b1111;
    idle(D + 6);
    ack   = 4'b0000;

    // Reset while key 1 is held and key 3 is mid-debounce.
    key_n[1] = 1'b0;
    idle(D + 5);
    key_n[3] = 1'b0;
    idle(7);
    async_reset("r028_reset");
    idle(3);
    reset_n = 1'b1;
    idle(D + 2);
    check_vec("r028_pre", key_press, 4'b0000);
    tick();
    check_vec("r028_repress", key_press, 4'b1010);
    key_n = 4'b1111;
    ack   = 4'b1111;
    idle(D + 6);
    ack   = 4'b0000;

    // Long hold on key 0: single pulse, or auto-repeat when enabled.
    key_n[0] = 1'b0;
    first  = -1;
    second = -1;
    third  = -1;
    cnt    = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (key_press[0]) begin
        cnt++;
        if (cnt == 1) first = k;
        if (cnt == 2) second = k;
        if (cnt == 3) third = k;
      end
    end
    check_int("r029_first", first, D + 3);
`ifdef KEY_CONDITIONER_REPEAT_EN
    check_int("r029_second", second, D + 3 + RD);
    check_int("r029_third", third, D + 3 + RD + RP);
    check_int("r029_count", cnt, 5);
`else
    check_int("r029_second", second, -1);
    check_int("r029_count", cnt, 1);
`endif
    key_n[0] = 1'b1;
    idle(D + 6);

    // Random key, ack and occasional reset traffic.
    for (int n = 0; n < 900; n++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(11) == 0) key_n[i] = ~key_n[i];
        ack[i] = ($urandom_range(5) == 0);
      end
      if ($urandom_range(299) == 0) begin
        async_reset("rand_reset");
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
